// File: rtl/mode_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mode_counter_pkg
//  Description : Shared types and constants for the mode_counter timer/counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package mode_counter_pkg;

    // Controller states: stopped, counting, and latched-at-terminal
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Encoding of the dir input
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage : mode_counter_pkg
`default_nettype wire

// File: rtl/mode_counter_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : mode_counter_prescaler
//  Description : Clock-enable divider. While enabled it produces a tick every
//                prescale+1 cycles; clear restarts the divide cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module mode_counter_prescaler #(
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      enable,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      tick
);

    localparam logic [PRESCALE_WIDTH-1:0] PSC_ONE = {{(PRESCALE_WIDTH-1){1'b0}}, 1'b1};

    logic [PRESCALE_WIDTH-1:0] psc_q;
    logic [PRESCALE_WIDTH-1:0] psc_d;
    logic                      psc_match;

    // The compare is against the live prescale value, so a mid-run change that
    // leaves psc above the new value lets psc run up and wrap before matching.
    assign psc_match = (psc_q == prescale);
    assign tick      = enable && psc_match;

    // Next divider value: clear wins, then advance or restart while enabled
    always_comb begin
        psc_d = psc_q;
        if (clear) begin
            psc_d = '0;
        end else if (enable) begin
            if (psc_match) begin
                psc_d = '0;
            end else begin
                psc_d = psc_q + PSC_ONE;
            end
        end
    end

    // Divider register
    always_ff @(posedge clk) begin
        if (rst) begin
            psc_q <= '0;
        end else begin
            psc_q <= psc_d;
        end
    end

endmodule : mode_counter_prescaler
`default_nettype wire

// File: rtl/mode_counter.sv
`default_nettype none
// ============================================================================
//  Module      : mode_counter
//  Description : General-purpose timer/counter with up/down direction,
//                programmable limit, wrap or one-shot stop, prescaler,
//                start/stop control, terminal-count pulse and done flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module mode_counter
    import mode_counter_pkg::*;
#(
    parameter int COUNT_WIDTH    = 16,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [COUNT_WIDTH-1:0]    load_in,
    input  logic [COUNT_WIDTH-1:0]    limit,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      dir,
    input  logic                      one_shot,
    output logic [COUNT_WIDTH-1:0]    count,
    output logic                      tc,
    output logic                      running,
    output logic                      done
);

    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    state_e                 state_q;
    state_e                 state_d;
    logic [COUNT_WIDTH-1:0] count_q;
    logic [COUNT_WIDTH-1:0] count_d;
    logic                   tc_q;
    logic                   tc_d;

    logic                   tick;
    logic                   psc_clear;
    logic                   psc_enable;

    // The divider only runs in RUN; any command that (re)starts or halts the
    // counter restarts the divide cycle. start while already running is a
    // no-op and must not disturb the divider phase.
    assign psc_enable = (state_q == RUN);
    assign psc_clear  = stop || load || (start && (state_q != RUN));

    mode_counter_prescaler #(
        .PRESCALE_WIDTH (PRESCALE_WIDTH)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .clear    (psc_clear),
        .enable   (psc_enable),
        .prescale (prescale),
        .tick     (tick)
    );

    // Next state, count and tc: stop > load/start > tick
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        tc_d    = 1'b0;

        if (stop) begin
            state_d = IDLE;
            if (load) begin
                count_d = load_in;
            end
        end else if (load || start) begin
            if (load) begin
                count_d = load_in;
            end
            if (start && (state_q != RUN)) begin
                state_d = RUN;
            end else if (load && (state_q == DONE)) begin
                state_d = IDLE;
            end
        end else if (tick) begin
            if (dir == DIR_UP) begin
                if (count_q >= limit) begin
                    tc_d = 1'b1;
                    if (one_shot) begin
                        state_d = DONE;
                    end else begin
                        count_d = '0;
                    end
                end else begin
                    count_d = count_q + CNT_ONE;
                end
            end else begin
                if (count_q == '0) begin
                    tc_d = 1'b1;
                    if (one_shot) begin
                        state_d = DONE;
                    end else begin
                        count_d = limit;
                    end
                end else begin
                    count_d = count_q - CNT_ONE;
                end
            end
        end
    end

    // State, count and terminal-count registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign count   = count_q;
    assign tc      = tc_q;
    assign running = (state_q == RUN);
    assign done    = (state_q == DONE);

endmodule : mode_counter
`default_nettype wire

// File: tb/tb_mode_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mode_counter
//  Description : Directed self-checking bench for mode_counter (4-bit count,
//                4-bit prescaler) with a queue of expected outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mode_counter;

    localparam int CW = 4;
    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          load;
    logic [CW-1:0] load_in;
    logic [CW-1:0] limit;
    logic [PW-1:0] prescale;
    logic          start;
    logic          stop;
    logic          dir;
    logic          one_shot;
    logic [CW-1:0] count;
    logic          tc;
    logic          running;
    logic          done;

    typedef struct {
        string         tag;
        logic [CW-1:0] c;
        logic          t;
        logic          r;
        logic          d;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    mode_counter #(
        .COUNT_WIDTH    (CW),
        .PRESCALE_WIDTH (PW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_in  (load_in),
        .limit    (limit),
        .prescale (prescale),
        .start    (start),
        .stop     (stop),
        .dir      (dir),
        .one_shot (one_shot),
        .count    (count),
        .tc       (tc),
        .running  (running),
        .done     (done)
    );

    always #5 clk = ~clk;

    // One clock: queue the expected result for the inputs now applied, let the
    // edge happen, then compare after it and drop the single-cycle commands.
    task automatic step(input string tag, input logic [CW-1:0] ec,
                        input logic et, input logic er, input logic ed);
        exp_t e;
        e.tag = tag; e.c = ec; e.t = et; e.r = er; e.d = ed;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        assert (count === e.c) else begin
            errors++;
            $error("FAIL %s count observed %0d expected %0d", e.tag, count, e.c);
        end
        checks++;
        assert (tc === e.t) else begin
            errors++;
            $error("FAIL %s tc observed %b expected %b", e.tag, tc, e.t);
        end
        checks++;
        assert (running === e.r) else begin
            errors++;
            $error("FAIL %s running observed %b expected %b", e.tag, running, e.r);
        end
        checks++;
        assert (done === e.d) else begin
            errors++;
            $error("FAIL %s done observed %b expected %b", e.tag, done, e.d);
        end
        load  = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; load_in = '0; limit = '0; prescale = '0;
        start = 1'b0; stop = 1'b0; dir = 1'b0; one_shot = 1'b0;

        // Reset state
        step("reset", 4'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // Up, wrap, limit 5, tick every cycle
        limit = 4'd5; dir = 1'b0; prescale = 4'd0; one_shot = 1'b0;
        start = 1'b1;
        step("up_start", 4'd0, 1'b0, 1'b1, 1'b0);
        step("up_1", 4'd1, 1'b0, 1'b1, 1'b0);
        step("up_2", 4'd2, 1'b0, 1'b1, 1'b0);
        step("up_3", 4'd3, 1'b0, 1'b1, 1'b0);
        step("up_4", 4'd4, 1'b0, 1'b1, 1'b0);
        step("up_5", 4'd5, 1'b0, 1'b1, 1'b0);
        step("up_wrap", 4'd0, 1'b1, 1'b1, 1'b0);
        step("up_after_wrap", 4'd1, 1'b0, 1'b1, 1'b0);
        stop = 1'b1;
        step("stop_hold", 4'd1, 1'b0, 1'b0, 1'b0);

        // Down, one-shot, prescale 2, from load+start of 3
        load_in = 4'd3; load = 1'b1; start = 1'b1;
        dir = 1'b1; one_shot = 1'b1; prescale = 4'd2;
        step("dn_load_start", 4'd3, 1'b0, 1'b1, 1'b0);
        step("dn_psc1", 4'd3, 1'b0, 1'b1, 1'b0);
        step("dn_psc2", 4'd3, 1'b0, 1'b1, 1'b0);
        step("dn_2", 4'd2, 1'b0, 1'b1, 1'b0);
        step("dn_2a", 4'd2, 1'b0, 1'b1, 1'b0);
        step("dn_2b", 4'd2, 1'b0, 1'b1, 1'b0);
        step("dn_1", 4'd1, 1'b0, 1'b1, 1'b0);
        step("dn_1a", 4'd1, 1'b0, 1'b1, 1'b0);
        step("dn_1b", 4'd1, 1'b0, 1'b1, 1'b0);
        step("dn_0", 4'd0, 1'b0, 1'b1, 1'b0);
        step("dn_0a", 4'd0, 1'b0, 1'b1, 1'b0);
        step("dn_0b", 4'd0, 1'b0, 1'b1, 1'b0);
        step("dn_terminal", 4'd0, 1'b1, 1'b0, 1'b1);
        step("dn_done_hold", 4'd0, 1'b0, 1'b0, 1'b1);
        start = 1'b1;
        step("restart_from_done", 4'd0, 1'b0, 1'b1, 1'b0);
        step("restart_psc1", 4'd0, 1'b0, 1'b1, 1'b0);
        step("restart_psc2", 4'd0, 1'b0, 1'b1, 1'b0);
        step("restart_terminal", 4'd0, 1'b1, 1'b0, 1'b1);

        // load while DONE -> IDLE
        load_in = 4'd9; load = 1'b1;
        step("load_in_done", 4'd9, 1'b0, 1'b0, 1'b0);

        // start+stop together while running up, limit 10, prescale 1
        limit = 4'd10; dir = 1'b0; one_shot = 1'b0; prescale = 4'd1;
        load_in = 4'd3; load = 1'b1; start = 1'b1;
        step("ss_load_start", 4'd3, 1'b0, 1'b1, 1'b0);
        step("ss_psc1", 4'd3, 1'b0, 1'b1, 1'b0);
        step("ss_4", 4'd4, 1'b0, 1'b1, 1'b0);
        start = 1'b1; stop = 1'b1;
        step("start_stop", 4'd4, 1'b0, 1'b0, 1'b0);
        step("idle_hold", 4'd4, 1'b0, 1'b0, 1'b0);
        start = 1'b1;
        step("resume", 4'd4, 1'b0, 1'b1, 1'b0);
        step("resume_psc1", 4'd4, 1'b0, 1'b1, 1'b0);
        step("resume_5", 4'd5, 1'b0, 1'b1, 1'b0);
        start = 1'b1;
        step("start_in_run", 4'd5, 1'b0, 1'b1, 1'b0);
        step("no_psc_restart", 4'd6, 1'b0, 1'b1, 1'b0);

        // Full range with limit all-ones
        limit = 4'hF; prescale = 4'd0; load_in = 4'd13; load = 1'b1;
        step("full_load", 4'd13, 1'b0, 1'b1, 1'b0);
        step("full_14", 4'd14, 1'b0, 1'b1, 1'b0);
        step("full_15", 4'd15, 1'b0, 1'b1, 1'b0);
        step("full_wrap", 4'd0, 1'b1, 1'b1, 1'b0);

        // Down wrap from 0 reloads limit
        dir = 1'b1; limit = 4'd7;
        step("dn_wrap_reload", 4'd7, 1'b1, 1'b1, 1'b0);
        step("dn_wrap_6", 4'd6, 1'b0, 1'b1, 1'b0);

        // Up with count above limit is terminal immediately
        dir = 1'b0; limit = 4'd2;
        step("above_limit", 4'd0, 1'b1, 1'b1, 1'b0);
        step("lim2_1", 4'd1, 1'b0, 1'b1, 1'b0);
        step("lim2_2", 4'd2, 1'b0, 1'b1, 1'b0);
        step("lim2_wrap", 4'd0, 1'b1, 1'b1, 1'b0);

        // limit 0, up, wrap: tc every tick
        limit = 4'd0;
        step("lim0_a", 4'd0, 1'b1, 1'b1, 1'b0);
        step("lim0_b", 4'd0, 1'b1, 1'b1, 1'b0);

        // Reset mid-run at count 9
        limit = 4'd12; load_in = 4'd8; load = 1'b1;
        step("pre_rst_load", 4'd8, 1'b0, 1'b1, 1'b0);
        step("pre_rst_9", 4'd9, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        step("rst_mid_run", 4'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // Tick coincident with load: load wins, no tc
        limit = 4'd5; load_in = 4'd5; load = 1'b1; start = 1'b1;
        step("tl_load_start", 4'd5, 1'b0, 1'b1, 1'b0);
        load_in = 4'd2; load = 1'b1;
        step("tick_vs_load", 4'd2, 1'b0, 1'b1, 1'b0);
        step("after_load_3", 4'd3, 1'b0, 1'b1, 1'b0);

        // stop+load: stop wins for state, load still updates count
        load_in = 4'd11; load = 1'b1; stop = 1'b1;
        step("stop_load", 4'd11, 1'b0, 1'b0, 1'b0);

        // Prescale lowered below psc mid-run: psc wraps before matching
        limit = 4'd15; prescale = 4'd4; start = 1'b1;
        step("psc_start", 4'd11, 1'b0, 1'b1, 1'b0);
        step("psc_to_2", 4'd11, 1'b0, 1'b1, 1'b0);
        step("psc_to_3", 4'd11, 1'b0, 1'b1, 1'b0);
        step("psc_at_3", 4'd11, 1'b0, 1'b1, 1'b0);
        prescale = 4'd1;
        for (int i = 0; i < 14; i++) begin
            step("psc_wrapping", 4'd11, 1'b0, 1'b1, 1'b0);
        end
        step("psc_wrap_tick", 4'd12, 1'b0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety net so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_mode_counter
`default_nettype wire
